pc_call_stack: RTL and testbench

- Parametrised successor to the CPU's 16-bit program counter.
- Registered PC with:
  - synchronous reset to a programmable vector
  - stall/enable
  - absolute load, relative branch and increment
  - hardware return-address stack supporting call/return
- Sits between instruction decode/branch unit and instruction-memory address port.
- Stack over/underflow is reported as sticky error flags for the CPU trap logic.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_return_stack.sv | 57 +++++
 rtl/pc_call_stack.sv | 76 +++++++
 tb/tb_pc_call_stack.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and command decode for the program counter with return-address stack.
package pc_pkg;

  localparam int unsigned PC_DEFAULT_WIDTH = 16;
  localparam int unsigned PC_DEFAULT_DEPTH = 8;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_REL,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // First match wins: ret > call > load+rel > load > inc > hold.
  function automatic pc_op_e pc_decode(input logic load, input logic rel,
                                       input logic inc, input logic call,
                                       input logic ret);
    if (ret)              return PC_RET;
    else if (call)        return PC_CALL;
    else if (load && rel) return PC_REL;
    else if (load)        return PC_LOAD;
    else if (inc)         return PC_INC;
    else                  return PC_HOLD;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Parametrised LIFO of return addresses; only the pointer is reset.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_DEFAULT_WIDTH,
  parameter int unsigned DEPTH = PC_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    ptr;
  logic [DW-1:0]    ptr_m1;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign ptr_m1  = ptr - DW'(1);
  assign wr_idx  = ptr[AW-1:0];
  assign rd_idx  = ptr_m1[AW-1:0];
  assign full    = (ptr == DW'(DEPTH));
  assign empty   = (ptr == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (do_push) begin
      ptr <= ptr + DW'(1);
    end else if (do_pop) begin
      ptr <= ptr_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_idx] <= data_in;
    end
  end

  assign data_out = mem[rd_idx];
  assign depth    = ptr;

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with stall, absolute/relative load, increment and call/return stack.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH        = PC_DEFAULT_WIDTH,
  parameter int unsigned     DEPTH        = PC_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic                   rel,
  input  logic                   inc,
  input  logic                   call,
  input  logic                   ret,
  output logic [WIDTH-1:0]       out,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_next_seq;
  logic [WIDTH-1:0] stack_top;
  logic             push;
  logic             pop;

  assign op          = pc_decode(load, rel, inc, call, ret);
  assign pc_next_seq = out + WIDTH'(1);
  // Stack only moves on accepted commands, so the top is read only when valid.
  assign push        = en && (op == PC_CALL) && !full;
  assign pop         = en && (op == PC_RET) && !empty;

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (pc_next_seq),
    .data_out (stack_top),
    .depth    (depth),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= RESET_VECTOR;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (en) begin
      unique case (op)
        PC_RET: begin
          if (!empty) out       <= stack_top;
          else        underflow <= 1'b1;
        end
        PC_CALL: begin
          if (!full) out      <= in;
          else       overflow <= 1'b1;
        end
        PC_REL:  out <= out + in;
        PC_LOAD: out <= in;
        PC_INC:  out <= pc_next_seq;
        default: out <= out;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: directed commands queue expectations, a monitor checks them.
module tb_pc_call_stack;

  logic        clk = 1'b0;
  logic        reset, en, load, rel, inc, call, ret;
  logic [15:0] in;
  logic [15:0] out, rv_out;
  logic [3:0]  depth, rv_depth;
  logic        full, empty, overflow, underflow;
  logic        rv_full, rv_empty, rv_overflow, rv_underflow;

  always #5 clk = ~clk;

  pc_call_stack #(
    .WIDTH        (16),
    .DEPTH        (8),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .in(in), .load(load), .rel(rel),
    .inc(inc), .call(call), .ret(ret), .out(out), .depth(depth),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  pc_call_stack #(
    .WIDTH        (16),
    .DEPTH        (8),
    .RESET_VECTOR (16'h0100)
  ) dut_rv (
    .clk(clk), .reset(reset), .en(en), .in(in), .load(load), .rel(rel),
    .inc(inc), .call(call), .ret(ret), .out(rv_out), .depth(rv_depth),
    .full(rv_full), .empty(rv_empty), .overflow(rv_overflow), .underflow(rv_underflow)
  );

  typedef struct {
    logic [15:0] out;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;
    bit          chk_rv;
    logic [15:0] rv_out;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising edge, one queued expectation is due.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("out", out, me.out);
        chk("depth", {12'b0, depth}, {12'b0, me.depth});
        chk("full", {15'b0, full}, {15'b0, (me.depth == 4'd8)});
        chk("empty", {15'b0, empty}, {15'b0, (me.depth == 4'd0)});
        chk("overflow", {15'b0, overflow}, {15'b0, me.ovf});
        chk("underflow", {15'b0, underflow}, {15'b0, me.unf});
        if (me.chk_rv) chk("rv_out", rv_out, me.rv_out);
      end
    end
  end

  task automatic cmd(input logic r, input logic e, input logic ld, input logic rl,
                     input logic ic, input logic cl, input logic rt, input logic [15:0] din,
                     input logic [15:0] eo, input logic [3:0] ed, input logic eov, input logic eun,
                     input bit crv = 1'b0, input logic [15:0] erv = 16'h0000);
    exp_t item;
    @(negedge clk);
    reset = r; en = e; load = ld; rel = rl; inc = ic; call = cl; ret = rt; in = din;
    item.out = eo; item.depth = ed; item.ovf = eov; item.unf = eun;
    item.chk_rv = crv; item.rv_out = erv;
    sb.push_back(item);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; rel = 1'b0; inc = 1'b0;
    call = 1'b0; ret = 1'b0; in = 16'h0000;

    // Reset and increment, both reset vectors
    cmd(1,1,0,0,0,0,0,16'h0000, 16'h0000,4'd0,0,0, 1,16'h0100);
    cmd(0,1,0,0,1,0,0,16'h0000, 16'h0001,4'd0,0,0, 1,16'h0101);
    cmd(0,1,0,0,1,0,0,16'h0000, 16'h0002,4'd0,0,0, 1,16'h0102);
    cmd(0,1,0,0,1,0,0,16'h0000, 16'h0003,4'd0,0,0, 1,16'h0103);

    // Load, relative branch, priority over inc, wrap
    cmd(0,1,1,0,0,0,0,16'h0010, 16'h0010,4'd0,0,0);
    cmd(0,1,1,1,0,0,0,16'hFFFC, 16'h000C,4'd0,0,0);
    cmd(0,1,1,0,1,0,0,16'h8000, 16'h8000,4'd0,0,0);
    cmd(0,1,0,1,0,0,0,16'h0005, 16'h8000,4'd0,0,0);
    cmd(0,1,1,0,0,0,0,16'hFFFF, 16'hFFFF,4'd0,0,0);
    cmd(0,1,0,0,1,0,0,16'h0000, 16'h0000,4'd0,0,0);

    // Nested call / return
    cmd(0,1,1,0,0,0,0,16'h0020, 16'h0020,4'd0,0,0);
    cmd(0,1,0,0,0,1,0,16'h0100, 16'h0100,4'd1,0,0);
    cmd(0,1,0,0,0,1,0,16'h0200, 16'h0200,4'd2,0,0);
    cmd(0,1,0,0,0,0,1,16'h0000, 16'h0101,4'd1,0,0);
    cmd(0,1,0,0,0,0,1,16'h0000, 16'h0021,4'd0,0,0);

    // Call from all-ones pushes 0
    cmd(0,1,1,0,0,0,0,16'hFFFF, 16'hFFFF,4'd0,0,0);
    cmd(0,1,0,0,0,1,0,16'h0400, 16'h0400,4'd1,0,0);
    cmd(0,1,0,0,0,0,1,16'h0000, 16'h0000,4'd0,0,0);

    // Fill to DEPTH, overflow, drain with sticky overflow
    for (int k = 0; k < 8; k++)
      cmd(0,1,0,0,0,1,0,16'(16'h1000 + 16'(k) * 16'h0010),
          16'(16'h1000 + 16'(k) * 16'h0010), 4'(k + 1), 0, 0);
    cmd(0,1,0,0,0,1,0,16'h0300, 16'h1070,4'd8,1,0);
    for (int k = 0; k < 8; k++)
      cmd(0,1,0,0,0,0,1,16'h0000,
          (k < 7) ? 16'(16'h1061 - 16'(k) * 16'h0010) : 16'h0001, 4'(7 - k), 1, 0);

    // Reset overrides a simultaneous call and clears flags
    cmd(1,1,0,0,0,1,0,16'h1234, 16'h0000,4'd0,0,0);

    // call+ret together, stall, underflow
    cmd(0,1,0,0,1,0,0,16'h0000, 16'h0001,4'd0,0,0);
    cmd(0,1,0,0,0,1,0,16'h0050, 16'h0050,4'd1,0,0);
    cmd(0,1,0,0,0,1,1,16'h0077, 16'h0002,4'd0,0,0);
    cmd(0,0,0,0,0,0,1,16'h0000, 16'h0002,4'd0,0,0);
    cmd(0,1,0,0,0,0,1,16'h0000, 16'h0002,4'd0,0,1);
    cmd(0,1,1,0,0,0,0,16'h0030, 16'h0030,4'd0,0,1);
    cmd(0,1,0,0,0,1,0,16'h0040, 16'h0040,4'd1,0,1);
    cmd(0,0,0,0,1,0,0,16'h0000, 16'h0040,4'd1,0,1);
    cmd(0,0,0,0,0,1,0,16'h0099, 16'h0040,4'd1,0,1);
    cmd(0,0,0,0,0,0,1,16'h0000, 16'h0040,4'd1,0,1);

    // Reset mid-stack discards contents
    cmd(0,1,0,0,0,1,0,16'h0050, 16'h0050,4'd2,0,1);
    cmd(0,1,0,0,0,1,0,16'h0060, 16'h0060,4'd3,0,1);
    cmd(1,1,0,0,0,1,0,16'h0070, 16'h0000,4'd0,0,0);
    cmd(0,1,0,0,0,0,1,16'h0000, 16'h0000,4'd0,0,1);
    cmd(0,1,0,0,0,1,0,16'h0010, 16'h0010,4'd1,0,1);
    cmd(0,1,0,0,0,0,1,16'h0000, 16'h0001,4'd0,0,1);

    @(negedge clk);
    en = 1'b0; call = 1'b0; ret = 1'b0; load = 1'b0; inc = 1'b0; rel = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
